// File: rtl/cross_bar_arbiter.sv
// Per-slave round-robin request arbiter for the crossbar: forwards one master's
// request to the slave and records accepted reads in the response-order FIFO.

package cross_bar_pkg;
   localparam int unsigned MASTER_N = 4;
   localparam int unsigned MASTER_W = $clog2(MASTER_N);
   localparam int unsigned SLAVE_N  = 4;
   typedef logic [MASTER_W-1:0] master_num_t;
endpackage

module cross_bar_arbiter
   import cross_bar_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = SLAVE_N - 1
) (
   input  logic                     clk,
   input  logic                     aresetn,
   input  logic [MASTER_N-1:0]      master_req,
   input  logic [MASTER_N*32-1:0]   master_addr,
   input  logic [MASTER_N-1:0]      master_cmd,
   input  logic [MASTER_N*32-1:0]   master_wdata,
   output logic [MASTER_N-1:0]      master_ack,
   output logic                     slave_req,
   output logic [31:0]              slave_addr,
   output logic                     slave_cmd,
   output logic [31:0]              slave_wdata,
   input  logic                     slave_ack,
   output logic                     fifo_wr,
   output logic [MASTER_W-1:0]      fifo_wdata,
   input  logic                     rsp_pop
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = (MAX_OUTSTANDING > 0) ? $clog2(MAX_OUTSTANDING + 1) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   master_num_t        grant_q, grant_d;
   master_num_t        last_grant_q, last_grant_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;
   logic [DATA_W-1:0]  slave_addr_q, slave_addr_d;
   logic               slave_cmd_q, slave_cmd_d;
   logic [DATA_W-1:0]  slave_wdata_q, slave_wdata_d;

   logic [DATA_W-1:0]  addr_arr  [MASTER_N];
   logic [DATA_W-1:0]  wdata_arr [MASTER_N];
   logic               read_ok;
   logic [MASTER_N-1:0] eligible;
   logic               pick_valid;
   master_num_t        pick_idx;
   master_num_t        scan;
   logic               ack_ok;

   always_comb begin
      for (int unsigned i = 0; i < MASTER_N; i++) begin
         addr_arr[i]  = master_addr[i*DATA_W +: DATA_W];
         wdata_arr[i] = master_wdata[i*DATA_W +: DATA_W];
      end
   end

   // Reads are masked once the FIFO would be full; writes always compete.
   always_comb begin
      read_ok  = (outstanding_q < CNT_W'(MAX_OUTSTANDING));
      eligible = master_req & (master_cmd | {MASTER_N{read_ok}});
   end

   // First eligible master after last_grant, wrapping.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      scan       = '0;
      for (int unsigned k = 1; k <= MASTER_N; k++) begin
         scan = MASTER_W'((32'(last_grant_q) + k) % MASTER_N);
         if (!pick_valid && eligible[scan]) begin
            pick_valid = 1'b1;
            pick_idx   = scan;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      slave_addr_d  = slave_addr_q;
      slave_cmd_d   = slave_cmd_q;
      slave_wdata_d = slave_wdata_q;
      master_ack    = '0;
      fifo_wr       = 1'b0;
      fifo_wdata    = '0;
      // A transaction being reset away must not ack or push.
      ack_ok        = slave_ack & aresetn;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d       = pick_idx;
               slave_addr_d  = addr_arr[pick_idx];
               slave_cmd_d   = master_cmd[pick_idx];
               slave_wdata_d = wdata_arr[pick_idx];
               state_d       = BUSY;
            end
         end
         BUSY: begin
            master_ack[grant_q] = ack_ok;
            if (ack_ok) begin
               last_grant_d = grant_q;
               state_d      = IDLE;
               if (!slave_cmd_q) begin
                  fifo_wr    = 1'b1;
                  fifo_wdata = grant_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      outstanding_d = outstanding_q;
      case ({fifo_wr, rsp_pop})
         2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
         2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - CNT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         last_grant_q  <= MASTER_W'(MASTER_N - 1);
         outstanding_q <= '0;
         slave_addr_q  <= '0;
         slave_cmd_q   <= 1'b0;
         slave_wdata_q <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         outstanding_q <= outstanding_d;
         slave_addr_q  <= slave_addr_d;
         slave_cmd_q   <= slave_cmd_d;
         slave_wdata_q <= slave_wdata_d;
      end
   end

   assign slave_req   = (state_q == BUSY);
   assign slave_addr  = slave_addr_q;
   assign slave_cmd   = slave_cmd_q;
   assign slave_wdata = slave_wdata_q;

endmodule
